data_bus_interconnect: RTL and testbench

//   Parametrised data-bus interconnect between the CPU data port and SLAVE_CNT memory-mapped slaves
//   (RAM, GPIO, timers, UART, ...). Replaces the fixed address decoder and read mux.
//   - Address decode: per-slave base/mask regions.
//   - Each transfer is registered and handled with a req/ready handshake, so slaves may insert wait states.
//   - Unmapped and hung accesses are reported on m_err.
//

---
 rtl/data_bus_interconnect_pkg.sv | 31 +++
 rtl/data_bus_interconnect_decoder.sv | 32 +++
 rtl/data_bus_interconnect.sv | 202 ++++++++++++++++++++
 tb/tb_data_bus_interconnect.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_interconnect_pkg.sv
// Shared definitions for the data-bus interconnect.
//   - Bus FSM state encoding (BUS_IDLE / BUS_ACTIVE / BUS_RESP).
//   - Default region map constants for the RAM and GPIO slaves.
//   - Default wait-state limit and the width of the optional timeout counter.
//   - idx_width(): width of a slave index for a given slave count.
// The timeout counter only exists when the BUS_TIMEOUT_EN macro is defined.
package data_bus_interconnect_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACTIVE = 2'd1,
    BUS_RESP   = 2'd2
  } bus_state_e;

  // Default region map: RAM in the low 64 KiB, GPIO at 0x8000_0000.
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE = 32'h8000_0000;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_0000;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Wide enough for any practical wait-state limit.
  localparam int TO_CNT_W = 16;

  // A single slave still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_bus_interconnect_decoder.sv
// bus_region_decoder: purely combinational address decoder.
//   addr        in   ADDR_W            address to decode
//   region_base in   SLAVE_CNT*ADDR_W  packed base addresses, slave i at [i*ADDR_W +: ADDR_W]
//   region_mask in   SLAVE_CNT*ADDR_W  packed masks, slave i hits when (addr & mask) == base
//   hit         out  1                 at least one region matches
//   idx         out  IDX_W             lowest matching slave index (0 when no hit)
module bus_region_decoder #(
  parameter int SLAVE_CNT = 4,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 2
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [SLAVE_CNT*ADDR_W-1:0] region_base,
  input  logic [SLAVE_CNT*ADDR_W-1:0] region_mask,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  // Scan from the top down so the lowest matching index is written last
  // and therefore wins when regions overlap.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
      if ((addr & region_mask[i*ADDR_W +: ADDR_W]) == region_base[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/data_bus_interconnect.sv
// data_bus_interconnect: CPU data port to SLAVE_CNT memory-mapped slaves.
// Each transfer is sampled in IDLE, registered onto the s_* bus, held until the
// selected slave answers with s_ready, then completed with a one-cycle m_ready.
// Optional feature macro: BUS_TIMEOUT_EN (wait-state timeout reported on m_err).
//
// Handshake: the CPU raises m_req with m_we/m_addr/m_wdata/m_mask and holds them
// until m_ready; the request is sampled only in IDLE, after which m_* is ignored.
// The selected slave sees s_sel[idx]=1 with stable s_* fields and completes the
// access in the first cycle it drives s_ready[idx]=1. m_ready is a one-cycle pulse,
// m_rdata/m_err are valid only while m_ready=1 and are 0 otherwise.
//
// Ports:
//   sysClk, sysRes          clock (rising edge), synchronous active-high reset
//   m_req/m_we/m_addr/
//   m_wdata/m_mask          CPU request
//   m_rdata/m_ready/m_err   CPU response
//   s_sel/s_we/s_addr/
//   s_wdata/s_mask          registered slave request (s_sel one-hot)
//   s_rdata/s_ready         packed slave responses
//   dbg_state               current FSM state (bus_state_e encoding)
module data_bus_interconnect
  import data_bus_interconnect_pkg::*;
#(
  parameter int                          SLAVE_CNT      = 4,
  parameter int                          ADDR_W         = 32,
  parameter int                          DATA_W         = 32,
  parameter logic [SLAVE_CNT*ADDR_W-1:0] REGION_BASE    = '0,
  parameter logic [SLAVE_CNT*ADDR_W-1:0] REGION_MASK    = '0,
  parameter int                          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        sysClk,
  input  logic                        sysRes,
  input  logic                        m_req,
  input  logic                        m_we,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W/8-1:0]         m_mask,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_ready,
  output logic                        m_err,
  output logic [SLAVE_CNT-1:0]        s_sel,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_mask,
  input  logic [SLAVE_CNT*DATA_W-1:0] s_rdata,
  input  logic [SLAVE_CNT-1:0]        s_ready,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = idx_width(SLAVE_CNT);

  bus_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
`ifdef BUS_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  bus_region_decoder #(
    .SLAVE_CNT (SLAVE_CNT),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W)
  ) u_decoder (
    .addr        (m_addr),
    .region_base (REGION_BASE),
    .region_mask (REGION_MASK),
    .hit         (dec_hit),
    .idx         (dec_idx)
  );

  // Only the latched slave's ready/rdata matter; everyone else is ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      BUS_IDLE: begin
        if (m_req) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            we_d    = m_we;
            addr_d  = m_addr;
            wdata_d = m_wdata;
            mask_d  = m_mask;
            err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = BUS_ACTIVE;
          end else begin
            // Unmapped: no slave is touched, the s_* registers keep their
            // previous contents and a write is simply dropped.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = BUS_RESP;
          end
        end
      end
      BUS_ACTIVE: begin
        // s_ready is checked first so it wins over a simultaneous timeout.
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = BUS_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = BUS_RESP;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
`endif
      end
      BUS_RESP: begin
        state_d = BUS_IDLE;
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysRes) begin
      state_q <= BUS_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // All outputs derive from flops only, so a reset clears them on the same edge.
  always_comb begin
    s_sel = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      if (state_q == BUS_ACTIVE && idx_q == IDX_W'(i)) begin
        s_sel[i] = 1'b1;
      end
    end
  end

  assign s_we      = (state_q == BUS_ACTIVE) && we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_mask    = mask_q;
  assign m_ready   = (state_q == BUS_RESP);
  assign m_err     = m_ready && err_q;
  assign m_rdata   = m_ready ? rdata_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Testbench for data_bus_interconnect (default build, BUS_TIMEOUT_EN undefined).
// Region map: 0 = RAM 0x0000_xxxx, 1 = GPIO 0x8000_xxxx,
// 2 = 0x000x_xxxx (overlaps RAM, RAM wins), 3 = 0x4xxx_xxxx.
module tb_data_bus_interconnect;
  import data_bus_interconnect_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam logic [N*AW-1:0] BASES = {32'h4000_0000, 32'h0000_0000, GPIO_BASE, RAM_BASE};
  localparam logic [N*AW-1:0] MASKS = {32'hF000_0000, 32'hFFF0_0000, GPIO_MASK, RAM_MASK};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_mask;
  logic [DW-1:0] m_rdata;
  logic          m_ready, m_err;
  logic [N-1:0]  s_sel;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [MW-1:0] s_mask;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]  s_ready;
  logic [1:0]    dbg_state;

  data_bus_interconnect #(
    .SLAVE_CNT   (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .REGION_BASE (BASES),
    .REGION_MASK (MASKS)
  ) dut (
    .sysClk    (clk),
    .sysRes    (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_mask    (m_mask),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_mask    (s_mask),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];   // {err, rdata} per issued transfer
  logic [DW-1:0] slave_data[N];
  logic [AW-1:0] ref_base[N];
  logic [AW-1:0] ref_mask[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // First listed region that contains the address; -1 when none does.
  function automatic int ref_decode(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & ref_mask[i]) == ref_base[i]) return i;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_rdata();
    for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = slave_data[i];
  endtask

  // Target slave answers in ACTIVE cycle number waits (cycle 1+waits);
  // with noise the other slaves toggle ready and data randomly.
  task automatic drive_slaves(input int idx, input int waits, input int c, input bit noise);
    for (int i = 0; i < N; i++) begin
      if (i == idx) begin
        s_ready[i] = (c == 1 + waits);
      end else begin
        s_ready[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) slave_data[i] = $urandom;
      end
    end
    apply_rdata();
  endtask

  // Called at a negedge with the DUT idle. Returns at a negedge with the DUT idle.
  task automatic do_xfer(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [MW-1:0] mask,
                         input int waits, input int exp_idx, input logic [DW-1:0] exp_rdata,
                         input logic exp_err, input bit noise);
    int lat;
    logic [N-1:0] exp_sel;
    logic [DW:0] exp;
    lat = (exp_idx < 0) ? 1 : 2 + waits;
    exp_q.push_back({exp_err, exp_rdata});
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_mask = mask;
    drive_slaves(exp_idx, waits, 0, noise);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      exp_sel = (exp_idx >= 0 && c < lat) ? N'(1 << exp_idx) : '0;
      check({tag, " s_sel"}, 64'(s_sel), 64'(exp_sel));
      if (exp_sel != '0) begin
        check({tag, " s_we"}, 64'(s_we), 64'(we));
        check({tag, " s_addr"}, 64'(s_addr), 64'(addr));
        check({tag, " s_wdata"}, 64'(s_wdata), 64'(wdata));
        check({tag, " s_mask"}, 64'(s_mask), 64'(mask));
      end else begin
        check({tag, " s_we_idle"}, 64'(s_we), 64'(0));
      end
      if (c < lat) begin
        check({tag, " m_ready_early"}, 64'(m_ready), 64'(0));
        check({tag, " m_rdata_zero"}, 64'(m_rdata), 64'(0));
      end else begin
        check({tag, " m_ready"}, 64'(m_ready), 64'(1));
        if (exp_q.size() == 0) begin
          check({tag, " scoreboard_underflow"}, 64'(1), 64'(0));
        end else begin
          exp = exp_q.pop_front();
          check({tag, " m_rdata"}, 64'(m_rdata), 64'(exp[DW-1:0]));
          check({tag, " m_err"}, 64'(m_err), 64'(exp[DW]));
        end
      end
      if (c == 1) begin
        // Request is released and scrambled after sampling; must be ignored.
        m_req = 1'b0; m_we = 1'($urandom_range(0, 1)); m_addr = $urandom;
        m_wdata = $urandom; m_mask = MW'($urandom);
      end
      drive_slaves(exp_idx, waits, c, noise);
    end
    drive_slaves(-1, 0, 0, 1'b0);
    @(negedge clk);
    check({tag, " idle_ready"}, 64'(m_ready), 64'(0));
    check({tag, " idle_sel"}, 64'(s_sel), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    int            waits;
    int            exp_idx;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, bad_sel, idx, waits, r;
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] wd, er;

    ref_base = '{RAM_BASE, GPIO_BASE, 32'h0000_0000, 32'h4000_0000};
    ref_mask = '{RAM_MASK, GPIO_MASK, 32'hFFF0_0000, 32'hF000_0000};

    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h8000_0004, 32'h55, 4'b0001, 3, 1, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, -1, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[4] = '{1'b0, 32'h8000_FFFC, 32'h0, 4'hF, 1, 1, 32'h1234_5678, 1'b0};
    tbl[5] = '{1'b0, 32'h4ABC_0000, 32'h0, 4'hF, 2, 3, 32'hA5A5_5A5A, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_FFF0, 32'hAABB_CCDD, 4'b1010, 0, 0, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 32'h2000_0000, 32'h1111_2222, 4'hF, 0, -1, 32'h0, 1'b1};
    tbl[8] = '{1'b0, 32'h0001_0000, 32'h0, 4'hF, 4, 2, 32'hCAFE_F00D, 1'b0};
    tbl[9] = '{1'b0, 32'h0010_0000, 32'h0, 4'hF, 0, -1, 32'h0, 1'b1};

    // Reset with a pending request: it must be ignored.
    rst = 1'b1; m_req = 1'b1; m_we = 1'b1; m_addr = 32'h10; m_wdata = '1; m_mask = '1;
    s_ready = '1;
    slave_data = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'hA5A5_5A5A};
    apply_rdata();
    repeat (3) @(negedge clk);
    check("reset m_ready", 64'(m_ready), 64'(0));
    check("reset m_err", 64'(m_err), 64'(0));
    check("reset m_rdata", 64'(m_rdata), 64'(0));
    check("reset s_sel", 64'(s_sel), 64'(0));
    check("reset s_we", 64'(s_we), 64'(0));
    check("reset s_addr", 64'(s_addr), 64'(0));
    check("reset s_wdata", 64'(s_wdata), 64'(0));
    check("reset s_mask", 64'(s_mask), 64'(0));
    check("reset state", 64'(dbg_state), 64'(0));
    rst = 1'b0; m_req = 1'b0; s_ready = '0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_xfer($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
              tbl[i].waits, tbl[i].exp_idx, tbl[i].exp_rdata, tbl[i].exp_err, 1'b0);
    end

    // Reset in the middle of ACTIVE aborts the access without m_ready.
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0010; m_wdata = '0; m_mask = '1;
    drive_slaves(-1, 0, 0, 1'b0);
    @(negedge clk);
    check("abort s_sel_c1", 64'(s_sel), 64'(4'b0010));
    m_req = 1'b0;
    @(negedge clk);
    check("abort s_sel_c2", 64'(s_sel), 64'(4'b0010));
    rst = 1'b1;
    @(negedge clk);
    check("abort s_sel", 64'(s_sel), 64'(0));
    check("abort m_ready", 64'(m_ready), 64'(0));
    check("abort s_addr", 64'(s_addr), 64'(0));
    check("abort state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    s_ready = '1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_ready) seen++;
    end
    check("abort no_ready", 64'(seen), 64'(0));
    s_ready = '0;
    do_xfer("after_abort", 1'b0, 32'h8000_0020, 32'h0, 4'hF, 1, 1,
            slave_data[1], 1'b0, 1'b0);

    // Without the timeout feature a silent slave stalls the bus indefinitely.
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h4000_0000; m_wdata = 32'h77; m_mask = 4'h1;
    drive_slaves(-1, 0, 0, 1'b0);
    @(negedge clk);
    m_req = 1'b0;
    seen = 0; bad_sel = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_ready) seen++;
      if (s_sel !== 4'b1000) bad_sel++;
    end
    check("hang no_ready", 64'(seen), 64'(0));
    check("hang sel_held", 64'(bad_sel), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hang cleared", 64'(s_sel), 64'(0));

    // Randomized traffic with other slaves toggling ready/data.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'h8000, 16'($urandom)};
        2: a = {12'h000, 20'($urandom)};
        3: a = {4'h4, 28'($urandom)};
        default: a = $urandom;
      endcase
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      waits = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) slave_data[i] = $urandom;
      apply_rdata();
      idx = ref_decode(a);
      er  = (idx < 0 || we) ? '0 : slave_data[idx];
      do_xfer($sformatf("rnd%0d", n), we, a, wd, MW'($urandom), waits, idx, er,
              idx < 0, 1'b1);
    end

    // ---------------- final report ----------------
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
